// File: rtl/mov_sequencer.sv
// mov_sequencer: decodes the 8086 MOV (B0-BF, 88-8B) byte stream into register-file read/write cycles.
// Latency: done pulses WRITE_HOLD+1 cycles after the last immediate byte, WRITE_HOLD+2 after a ModR/M byte.
// Backpressure: byte_ready is low while reading or writing; no byte is consumed until byte_valid && byte_ready.
//
// Build option XCHG_EN: when defined, 86/87 (XCHG reg, rm; register form only) are also accepted.
//
// Ports:
//   clk, reset (async, active-low)      clock and reset
//   byte_in/byte_valid/byte_ready       instruction byte stream handshake
//   rf_direction (1 = write)            register-file transfer direction
//   rf_word_size (1 = 16-bit)           register-file width select
//   rf_reg_sel, rf_data_in, rf_data_out register-file select and data
//   busy, done, illegal                 status; done/illegal are one-cycle pulses
module mov_sequencer #(
  parameter int WRITE_HOLD = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        rf_direction,
  output logic        rf_word_size,
  output logic [2:0]  rf_reg_sel,
  output logic [15:0] rf_data_in,
  input  logic [15:0] rf_data_out,
  output logic        busy,
  output logic        done,
  output logic        illegal
);

  typedef enum logic [2:0] {
    S_OPC    = 3'd0,
    S_MODRM  = 3'd1,
    S_IMM_LO = 3'd2,
    S_IMM_HI = 3'd3,
    S_READ   = 3'd4,
    S_WRITE  = 3'd5
  } state_t;

  localparam logic [1:0] HOLD_LAST = 2'(WRITE_HOLD - 1);

  state_t      state_q, state_d;
  logic        w_q, w_d;
  logic        d_bit_q, d_bit_d;     // opcode bit 1: 1 = reg is destination
  logic [2:0]  src_q, src_d;
  logic [2:0]  dst_q, dst_d;
  logic [15:0] data_q, data_d;
  logic [1:0]  hold_q, hold_d;
  logic        done_q, done_d;
  logic        illegal_q, illegal_d;
`ifdef XCHG_EN
  logic        xchg_q, xchg_d;
  logic        second_q, second_d;   // second read / second write of an exchange
  logic [15:0] data2_q, data2_d;
`endif

  logic accept;

  // 8086 register code to register-file encoding. 16-bit codes 4..7 are
  // rejected before this is called, so code[2] only matters for bytes.
  function automatic logic [2:0] map_sel(input logic w, input logic [2:0] code);
    logic [2:0] sel;
    if (w) begin
      case (code[1:0])
        2'd0:    sel = 3'd0;  // AX
        2'd1:    sel = 3'd2;  // CX
        2'd2:    sel = 3'd3;  // DX
        default: sel = 3'd1;  // BX
      endcase
    end else begin
      case (code)
        3'd0:    sel = 3'd0;  // AL
        3'd1:    sel = 3'd4;  // CL
        3'd2:    sel = 3'd6;  // DL
        3'd3:    sel = 3'd2;  // BL
        3'd4:    sel = 3'd1;  // AH
        3'd5:    sel = 3'd5;  // CH
        3'd6:    sel = 3'd7;  // DH
        default: sel = 3'd3;  // BH
      endcase
    end
    return sel;
  endfunction

  assign accept     = byte_valid && byte_ready;
  assign busy       = (state_q != S_OPC);
  assign done       = done_q;
  assign illegal    = illegal_q;
  assign byte_ready = (state_q == S_OPC) || (state_q == S_MODRM) ||
                      (state_q == S_IMM_LO) || (state_q == S_IMM_HI);

  always_comb begin
    state_d      = state_q;
    w_d          = w_q;
    d_bit_d      = d_bit_q;
    src_d        = src_q;
    dst_d        = dst_q;
    data_d       = data_q;
    hold_d       = hold_q;
    done_d       = 1'b0;
    illegal_d    = 1'b0;
`ifdef XCHG_EN
    xchg_d       = xchg_q;
    second_d     = second_q;
    data2_d      = data2_q;
`endif
    rf_direction = 1'b0;
    rf_word_size = 1'b0;
    rf_reg_sel   = 3'd0;
    rf_data_in   = 16'h0000;

    case (state_q)
      S_OPC: begin
        if (accept) begin
`ifdef XCHG_EN
          xchg_d   = 1'b0;
          second_d = 1'b0;
`endif
          casez (byte_in)
            8'b1011_0???: begin
              w_d     = 1'b0;
              dst_d   = map_sel(1'b0, byte_in[2:0]);
              state_d = S_IMM_LO;
            end
            8'b1011_1???: begin
              if (byte_in[2]) begin
                illegal_d = 1'b1;  // SP/BP/SI/DI are not in the register file
              end else begin
                w_d     = 1'b1;
                dst_d   = map_sel(1'b1, byte_in[2:0]);
                state_d = S_IMM_LO;
              end
            end
            8'b1000_10??: begin
              w_d     = byte_in[0];
              d_bit_d = byte_in[1];
              state_d = S_MODRM;
            end
`ifdef XCHG_EN
            8'b1000_011?: begin
              // Exchange reads reg first, so it routes like 88/89 (src = reg).
              w_d     = byte_in[0];
              d_bit_d = 1'b0;
              xchg_d  = 1'b1;
              state_d = S_MODRM;
            end
`endif
            default: illegal_d = 1'b1;
          endcase
        end
      end

      S_MODRM: begin
        if (accept) begin
          if ((byte_in[7:6] != 2'b11) || (w_q && (byte_in[5] || byte_in[2]))) begin
            illegal_d = 1'b1;
            state_d   = S_OPC;
          end else begin
            if (d_bit_q) begin
              dst_d = map_sel(w_q, byte_in[5:3]);
              src_d = map_sel(w_q, byte_in[2:0]);
            end else begin
              src_d = map_sel(w_q, byte_in[5:3]);
              dst_d = map_sel(w_q, byte_in[2:0]);
            end
            state_d = S_READ;
          end
        end
      end

      S_IMM_LO: begin
        if (accept) begin
          data_d  = {8'h00, byte_in};
          hold_d  = 2'd0;
          state_d = w_q ? S_IMM_HI : S_WRITE;
        end
      end

      S_IMM_HI: begin
        if (accept) begin
          data_d[15:8] = byte_in;
          hold_d       = 2'd0;
          state_d      = S_WRITE;
        end
      end

      S_READ: begin
        rf_word_size = w_q;
        hold_d       = 2'd0;
`ifdef XCHG_EN
        rf_reg_sel = second_q ? dst_q : src_q;
        if (xchg_q && !second_q) begin
          data_d   = w_q ? rf_data_out : {8'h00, rf_data_out[7:0]};
          second_d = 1'b1;
        end else if (xchg_q) begin
          data2_d  = w_q ? rf_data_out : {8'h00, rf_data_out[7:0]};
          second_d = 1'b0;
          state_d  = S_WRITE;
        end else begin
          data_d  = w_q ? rf_data_out : {8'h00, rf_data_out[7:0]};
          state_d = S_WRITE;
        end
`else
        rf_reg_sel = src_q;
        data_d     = w_q ? rf_data_out : {8'h00, rf_data_out[7:0]};
        state_d    = S_WRITE;
`endif
      end

      S_WRITE: begin
        rf_direction = 1'b1;
        rf_word_size = w_q;
`ifdef XCHG_EN
        // First write: rm <- reg. Second write: reg <- rm.
        rf_reg_sel = second_q ? src_q : dst_q;
        rf_data_in = second_q ? data2_q : data_q;
`else
        rf_reg_sel = dst_q;
        rf_data_in = data_q;
`endif
        if (!w_q) rf_data_in[15:8] = 8'h00;
        if (hold_q == HOLD_LAST) begin
          hold_d = 2'd0;
`ifdef XCHG_EN
          if (xchg_q && !second_q) begin
            second_d = 1'b1;
          end else begin
            state_d = S_OPC;
            done_d  = 1'b1;
          end
`else
          state_d = S_OPC;
          done_d  = 1'b1;
`endif
        end else begin
          hold_d = hold_q + 2'd1;
        end
      end

      default: state_d = S_OPC;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_OPC;
      w_q       <= 1'b0;
      d_bit_q   <= 1'b0;
      src_q     <= 3'd0;
      dst_q     <= 3'd0;
      data_q    <= 16'h0000;
      hold_q    <= 2'd0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef XCHG_EN
      xchg_q    <= 1'b0;
      second_q  <= 1'b0;
      data2_q   <= 16'h0000;
`endif
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      d_bit_q   <= d_bit_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      data_q    <= data_d;
      hold_q    <= hold_d;
      done_q    <= done_d;
      illegal_q <= illegal_d;
`ifdef XCHG_EN
      xchg_q    <= xchg_d;
      second_q  <= second_d;
      data2_q   <= data2_d;
`endif
    end
  end

endmodule

// File: tb/tb_mov_sequencer.sv
// tb_mov_sequencer: directed byte sequences against a register-file model;
// expected reads/writes are queued as bytes are driven and popped by a monitor.
module tb_mov_sequencer;

  localparam int WH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        rf_direction;
  logic        rf_word_size;
  logic [2:0]  rf_reg_sel;
  logic [15:0] rf_data_in;
  logic [15:0] rf_data_out;
  logic        busy;
  logic        done;
  logic        illegal;

  mov_sequencer #(.WRITE_HOLD(WH)) dut (
    .clk(clk), .reset(reset),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .rf_direction(rf_direction), .rf_word_size(rf_word_size),
    .rf_reg_sel(rf_reg_sel), .rf_data_in(rf_data_in), .rf_data_out(rf_data_out),
    .busy(busy), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [2:0] sel; logic w; logic [15:0] data; } wr_t;
  typedef struct packed { logic [2:0] sel; logic w; } rd_t;

  wr_t exp_wr[$];
  rd_t exp_rd[$];

  int n_pass = 0;
  int n_total = 0;

  // Register-file model: 16-bit sel 0..3 = AX,BX,CX,DX; 8-bit sel = {reg, high}.
  logic [15:0] rf [4];
  int  run = 0;
  wr_t cur = '0;
  bit  dir_seen = 0;
  int  acc_cnt = 0;

  always_comb begin
    if (rf_word_size) rf_data_out = rf[rf_reg_sel[1:0]];
    else if (rf_reg_sel[0]) rf_data_out = {8'h00, rf[rf_reg_sel[2:1]][15:8]};
    else rf_data_out = {8'h00, rf[rf_reg_sel[2:1]][7:0]};
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Monitor: each run of WH write cycles is one register write.
  always @(negedge clk) begin
    if (!reset) begin
      run = 0;
    end else begin
      if (byte_valid && byte_ready) acc_cnt++;
      if (rf_direction) begin
        dir_seen = 1;
        if (run == 0) begin
          if (exp_wr.size() == 0) check("unexpected_write", 32'(rf_direction), 0);
          else cur = exp_wr.pop_front();
        end
        check("wr_sel", 32'(rf_reg_sel), 32'(cur.sel));
        check("wr_word", 32'(rf_word_size), 32'(cur.w));
        check("wr_data", 32'(rf_data_in), 32'(cur.data));
        run++;
        if (run == WH) begin
          if (cur.w) rf[cur.sel[1:0]] = cur.data;
          else if (cur.sel[0]) rf[cur.sel[2:1]][15:8] = cur.data[7:0];
          else rf[cur.sel[2:1]][7:0] = cur.data[7:0];
          run = 0;
        end
      end else begin
        if (run != 0) begin
          check("wr_window_len", run, WH);
          run = 0;
        end
        if (busy && !byte_ready) begin
          if (exp_rd.size() == 0) check("unexpected_read", 32'(busy), 0);
          else begin
            rd_t r;
            r = exp_rd.pop_front();
            check("rd_sel", 32'(rf_reg_sel), 32'(r.sel));
            check("rd_word", 32'(rf_word_size), 32'(r.w));
          end
        end
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    byte_in = b;
    byte_valid = 1'b1;
    while (!byte_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!byte_ready) check("send_timeout", 32'(byte_ready), 1);
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && !illegal && n < 40);
    check({tag, "_latency"}, n, exp_lat);
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) rf[i] = 16'h0000;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_byte_ready", 32'(byte_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_dir", 32'(rf_direction), 0);
    check("rst_word", 32'(rf_word_size), 0);
    check("rst_sel", 32'(rf_reg_sel), 0);
    check("rst_data_in", 32'(rf_data_in), 0);
    check("rst_done", 32'(done), 0);
    check("rst_illegal", 32'(illegal), 0);
    reset = 1'b1;

    // MOV AH, 5A
    exp_wr.push_back('{sel: 3'd1, w: 1'b0, data: 16'h005A});
    send(8'hB4);
    check("imm8_busy", 32'(busy), 1);
    send(8'h5A);
    wait_done("mov_ah", WH + 1);

    // MOV BX, 1234: three bytes accepted
    begin
      int a0;
      a0 = acc_cnt;
      exp_wr.push_back('{sel: 3'd1, w: 1'b1, data: 16'h1234});
      send(8'hBB);
      send(8'h34);
      send(8'h12);
      wait_done("mov_bx", WH + 1);
      check("mov_bx_accepts", acc_cnt - a0, 3);
    end

    // MOV CX, BX (89 D9)
    exp_rd.push_back('{sel: 3'd1, w: 1'b1});
    exp_wr.push_back('{sel: 3'd2, w: 1'b1, data: 16'h1234});
    send(8'h89);
    send(8'hD9);
    wait_done("mov_cx_bx", WH + 2);

    // Illegal: MOV SP, imm16 and memory-form ModR/M
    dir_seen = 0;
    send(8'hBC);
    @(negedge clk);
    check("ill_bc_pulse", 32'(illegal), 1);
    check("ill_bc_busy", 32'(busy), 0);
    @(negedge clk);
    check("ill_bc_one_cycle", 32'(illegal), 0);
    send(8'h8A);
    send(8'h06);
    @(negedge clk);
    check("ill_modrm_pulse", 32'(illegal), 1);
    check("ill_modrm_busy", 32'(busy), 0);
    check("ill_no_write", 32'(dir_seen), 0);

    // MOV AL, 11 then back-to-back MOV CL, 22
    exp_wr.push_back('{sel: 3'd0, w: 1'b0, data: 16'h0011});
    send(8'hB0);
    send(8'h11);
    byte_in = 8'hB1;
    byte_valid = 1'b1;
    for (int k = 1; k <= WH + 1; k++) begin
      @(negedge clk);
      if (k == 1) check("write_not_ready", 32'(byte_ready), 0);
    end
    check("b2b_done", 32'(done), 1);
    check("b2b_ready", 32'(byte_ready), 1);
    @(posedge clk);
    #1 byte_valid = 1'b0;
    check("b2b_accepted", 32'(busy), 1);
    exp_wr.push_back('{sel: 3'd4, w: 1'b0, data: 16'h0022});
    send(8'h22);
    wait_done("mov_cl", WH + 1);

    // XCHG CL, AL (86 C8)
`ifdef XCHG_EN
    exp_rd.push_back('{sel: 3'd4, w: 1'b0});
    exp_rd.push_back('{sel: 3'd0, w: 1'b0});
    exp_wr.push_back('{sel: 3'd0, w: 1'b0, data: 16'h0022});
    exp_wr.push_back('{sel: 3'd4, w: 1'b0, data: 16'h0011});
    send(8'h86);
    send(8'hC8);
    wait_done("xchg", 2 + 2 * WH + 1);
`else
    send(8'h86);
    @(negedge clk);
    check("xchg_illegal", 32'(illegal), 1);
`endif

    // MOV DL, AL (88 C2): copies AL, showing whether the exchange happened
    exp_rd.push_back('{sel: 3'd0, w: 1'b0});
`ifdef XCHG_EN
    exp_wr.push_back('{sel: 3'd6, w: 1'b0, data: 16'h0022});
`else
    exp_wr.push_back('{sel: 3'd6, w: 1'b0, data: 16'h0011});
`endif
    send(8'h88);
    send(8'hC2);
    wait_done("mov_dl_al", WH + 2);

    // Reset on the first write cycle of MOV AL, 7F
    send(8'hB0);
    send(8'h7F);
    check("pre_rst_dir", 32'(rf_direction), 1);
    #1 reset = 1'b0;
    #1;
    check("midrst_dir", 32'(rf_direction), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_ready", 32'(byte_ready), 1);
    check("midrst_sel", 32'(rf_reg_sel), 0);
    check("midrst_data_in", 32'(rf_data_in), 0);
    check("midrst_word", 32'(rf_word_size), 0);
    @(negedge clk);
    reset = 1'b1;
    byte_in = 8'hB7;
    byte_valid = 1'b1;
    @(posedge clk);
    #1 byte_valid = 1'b0;
    check("post_rst_first_accept", 32'(busy), 1);
    exp_wr.push_back('{sel: 3'd3, w: 1'b0, data: 16'h005C});
    send(8'h5C);
    wait_done("mov_bh", WH + 1);

    repeat (2) @(negedge clk);
    check("wr_queue_empty", exp_wr.size(), 0);
    check("rd_queue_empty", exp_rd.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mov_sequencer.md
MOV_SEQUENCER -- requirements
Module: mov_sequencer

Interface
REQ-001 SHALL have parameter WRITE_HOLD, default 2, the number of cycles (1..4) that rf_direction is held high per register write.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port byte_in, input, 8 bits: instruction byte stream.
REQ-005 SHALL have port byte_valid, input, 1 bit: byte_in is valid.
REQ-006 SHALL have port byte_ready, output, 1 bit: the sequencer accepts a byte this cycle.
REQ-007 SHALL have port rf_direction, output, 1 bit: register file control, 1 = import (write), 0 = export (read).
REQ-008 SHALL have port rf_word_size, output, 1 bit: register file width select, 1 = 16-bit.
REQ-009 SHALL have port rf_reg_sel, output, 3 bits: register file select, in register-file encoding.
REQ-010 SHALL have port rf_data_in, output, 16 bits: write data to the register file.
REQ-011 SHALL have port rf_data_out, input, 16 bits: read data from the register file; 8-bit reads are zero-extended.
REQ-012 SHALL have port busy, output, 1 bit: high in any state other than S_OPC.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when an instruction retires.
REQ-014 SHALL have port illegal, output, 1 bit: one-cycle pulse when an instruction is rejected.

Function
REQ-015 SHALL implement the states S_OPC, S_MODRM, S_IMM_LO, S_IMM_HI, S_READ, S_WRITE.
REQ-016 SHALL drive byte_ready high only in S_OPC, S_MODRM, S_IMM_LO and S_IMM_HI; a byte is consumed only on a clk edge with byte_valid and byte_ready both high.
REQ-017 SHALL handle opcodes B0-B7 (MOV r8, imm8) as: S_OPC -> S_IMM_LO -> S_WRITE.
REQ-018 SHALL handle opcodes B8-BF (MOV r16, imm16) as: S_OPC -> S_IMM_LO -> S_IMM_HI -> S_WRITE; the immediate is little-endian.
REQ-019 SHALL handle opcodes 88/89 (destination = rm, source = reg) and 8A/8B (destination = reg, source = rm) as: S_OPC -> S_MODRM -> S_READ -> S_WRITE; opcode bit 0 = w.
REQ-020 SHALL translate 8-bit 8086 codes 0..7 (AL, CL, DL, BL, AH, CH, DH, BH) to rf_reg_sel 0, 4, 6, 2, 1, 5, 7, 3.
REQ-021 SHALL translate 16-bit codes 0..3 (AX, CX, DX, BX) to rf_reg_sel 0, 2, 3, 1.
REQ-022 SHALL treat 16-bit codes 4..7, ModR/M mod != 11, and any other opcode as illegal: pulse illegal the cycle after the offending byte, perform no write, and return to S_OPC.
REQ-023 SHALL, in S_READ (exactly 1 cycle), drive rf_direction=0 with the source selection, and capture rf_data_out at the ending edge.
REQ-024 SHALL, in S_WRITE, hold rf_direction=1, rf_word_size, rf_reg_sel and rf_data_in stable for exactly WRITE_HOLD cycles, then go to S_OPC and pulse done in the following cycle.
REQ-025 SHALL keep rf_direction=0 in every state except S_WRITE.
REQ-026 SHALL drive rf_data_in in 8-bit writes as {8'h00, data}.
REQ-027 SHALL allow back-to-back instructions: an opcode byte may be accepted in the same cycle that done is high.
REQ-028 SHALL hold state while byte_valid is low in any byte-accepting state, with no timeout.

Reset
REQ-029 SHALL, on reset low, immediately enter S_OPC and force byte_ready=1, rf_direction=0, rf_word_size=0, rf_reg_sel=0, rf_data_in=0, busy=0, done=0, illegal=0, clearing the captured data, even mid-write.
REQ-030 SHALL deassert reset synchronously to clk, with the first byte accepted on the first edge after release.

Configuration
REQ-031 SHALL, when XCHG_EN is defined, accept 86/87 (XCHG reg, rm; mod=11) as: S_MODRM -> S_READ (reg) -> S_READ (rm) -> S_WRITE (rm <- reg) -> S_WRITE (reg <- rm), with done after the second write.
REQ-032 SHALL, when XCHG_EN is undefined, treat 86/87 as illegal per REQ-022.

Verification
REQ-033 SHALL verify: bytes B4, 5A -> one S_WRITE window of WRITE_HOLD cycles with word_size=0, sel=1 (AH), data_in=005A, then done.
REQ-034 SHALL verify: bytes BB, 34, 12 -> a write with word_size=1, sel=1 (BX), data_in=1234; 3 accepted bytes, then 2 write cycles, then done.
REQ-035 SHALL verify: BX preloaded to 1234, then bytes 89, D9 (MOV CX, BX) -> read with sel=1, word_size=1, then write with sel=2, data_in=1234.
REQ-036 SHALL verify: bytes BC, then 8A 06 -> illegal pulses after BC and after 06, with rf_direction never 1.
REQ-037 SHALL verify: reset asserted on the first S_WRITE cycle of B0, 7F -> rf_direction=0 within the reset cycle, then S_OPC with busy=0.
REQ-038 SHALL verify: with XCHG_EN defined, AL=11 and CL=22, bytes 86 C8 -> AL=22 and CL=11, then done; without XCHG_EN -> illegal.
